// File: rtl/mux_arb_pkg.sv
// Shared types and defaults for the round-robin 2:1 mux arbiter.
// Imported by the output register and the arbiter top.
package mux_arb_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int BURST_LEN_DEF = 4;
  localparam int CNT_W         = 4;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_A,
    GRANT_B
  } arb_state_e;

endpackage

// File: rtl/mux_out_reg.sv
// Registered valid/data output stage: load on accept, drain on ready,
// otherwise hold so the data stays stable under backpressure.
module mux_out_reg
  import mux_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              y_ready_i,
  output logic              y_valid_o,
  output logic [DATA_W-1:0] y_data_o,
  output logic              slot_free
);

  assign slot_free = !y_valid_o || y_ready_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      y_valid_o <= 1'b0;
      y_data_o  <= '0;
    end else if (load) begin
      y_valid_o <= 1'b1;
      y_data_o  <= load_data;
    end else if (y_ready_i) begin
      y_valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of a shared 2:1 data mux with bounded bursts
// and a registered valid/ready output.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid_i,
  input  logic [DATA_W-1:0] a_data_i,
  output logic              a_ready_o,
  input  logic              b_valid_i,
  input  logic [DATA_W-1:0] b_data_i,
  output logic              b_ready_o,
  output logic              y_valid_o,
  output logic [DATA_W-1:0] y_data_o,
  input  logic              y_ready_i,
  output logic              sel_o
);

  localparam logic [CNT_W-1:0] BL = CNT_W'(BURST_LEN);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             last_q, last_d;
  logic             slot_free;
  logic             cnt_full;
  logic             fire_a, fire_b, fire;
  logic [DATA_W-1:0] sel_data;

  assign cnt_full = (cnt_q == BL);
  assign fire_a   = a_valid_i && a_ready_o;
  assign fire_b   = b_valid_i && b_ready_o;
  assign fire     = fire_a || fire_b;
  assign cnt_inc  = cnt_full ? cnt_q : cnt_q + CNT_W'(fire);
  assign sel_data = sel_o ? b_data_i : a_data_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (a_valid_i && b_valid_i)
          state_d = last_q ? GRANT_A : GRANT_B;
        else if (a_valid_i)
          state_d = GRANT_A;
        else if (b_valid_i)
          state_d = GRANT_B;
      end
      GRANT_A: begin
        if (b_valid_i && (cnt_inc == BL || !a_valid_i)) begin
          state_d = GRANT_B;
          cnt_d   = '0;
          last_d  = 1'b0;
        end else if (!a_valid_i && !b_valid_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          last_d  = 1'b0;
        end
      end
      GRANT_B: begin
        if (a_valid_i && (cnt_inc == BL || !b_valid_i)) begin
          state_d = GRANT_A;
          cnt_d   = '0;
          last_d  = 1'b1;
        end else if (!a_valid_i && !b_valid_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          last_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A full burst yields to a waiting peer before accepting another beat.
  always_comb begin
    a_ready_o = (state_q == GRANT_A) && slot_free
             && !(cnt_full && b_valid_i);
    b_ready_o = (state_q == GRANT_B) && slot_free
             && !(cnt_full && a_valid_i);
    sel_o     = (state_q == GRANT_B);
  end

  mux_out_reg #(
    .DATA_W(DATA_W)
  ) u_out (
    .clk      (clk),
    .reset    (reset),
    .load     (fire),
    .load_data(sel_data),
    .y_ready_i(y_ready_i),
    .y_valid_o(y_valid_o),
    .y_data_o (y_data_o),
    .slot_free(slot_free)
  );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed and randomized checks of mux_rr_arbiter against
// expectations derived from the arbitration rules.
module tb_mux_rr_arbiter;

  localparam int BL = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_valid, b_valid, y_ready;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready, y_valid, sel;
  logic [7:0] y_data;

  int errors = 0;
  int checks = 0;

  // reference model: owner 0 none, 1 A, 2 B
  int       m_own, m_cnt, m_last;
  bit       m_yv, m_ar, m_br;
  bit [7:0] m_yd;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.DATA_W(8), .BURST_LEN(BL)) dut (
    .clk      (clk),
    .reset    (reset),
    .a_valid_i(a_valid),
    .a_data_i (a_data),
    .a_ready_o(a_ready),
    .b_valid_i(b_valid),
    .b_data_i (b_data),
    .b_ready_o(b_ready),
    .y_valid_o(y_valid),
    .y_data_o (y_data),
    .y_ready_i(y_ready),
    .sel_o    (sel)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    a_valid = 0; b_valid = 0; y_ready = 1;
    a_data = 0; b_data = 0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic model_reset;
    m_own = 0; m_cnt = 0; m_last = 2;
    m_yv = 0; m_yd = 0;
  endtask

  task automatic model_comb;
    bit slot;
    slot = !m_yv || y_ready;
    m_ar = (m_own == 1) && slot && !(m_cnt == BL && b_valid);
    m_br = (m_own == 2) && slot && !(m_cnt == BL && a_valid);
  endtask

  task automatic model_tick;
    bit fa, fb, mv, ov;
    int n;
    fa = a_valid && m_ar;
    fb = b_valid && m_br;
    if (reset) begin
      model_reset();
      return;
    end
    if (fa || fb) begin
      m_yv = 1;
      m_yd = fa ? a_data : b_data;
    end else if (y_ready) m_yv = 0;
    if (m_own == 0) begin
      m_cnt = 0;
      if (a_valid && b_valid) m_own = (m_last == 1) ? 2 : 1;
      else if (a_valid) m_own = 1;
      else if (b_valid) m_own = 2;
    end else begin
      mv = (m_own == 1) ? a_valid : b_valid;
      ov = (m_own == 1) ? b_valid : a_valid;
      n  = m_cnt + ((fa || fb) ? 1 : 0);
      if (n > BL) n = BL;
      if (ov && (n == BL || !mv)) begin
        m_last = m_own; m_own = 3 - m_own; m_cnt = 0;
      end else if (!mv && !ov) begin
        m_last = m_own; m_own = 0; m_cnt = 0;
      end else m_cnt = n;
    end
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    checks += 5;
    if (y_valid !== 1'b0) begin errors++; $display("FAIL rst_y_valid got=%0h exp=0", y_valid); end
    if (y_data !== 8'h00) begin errors++; $display("FAIL rst_y_data got=%0h exp=0", y_data); end
    if (sel !== 1'b0) begin errors++; $display("FAIL rst_sel got=%0h exp=0", sel); end
    if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_a_ready got=%0h exp=0", a_ready); end
    if (b_ready !== 1'b0) begin errors++; $display("FAIL rst_b_ready got=%0h exp=0", b_ready); end
    tick();
  endtask

  task automatic test_a_stream;
    y_ready = 1; a_valid = 1; a_data = 8'h11;
    tick();
    for (int i = 0; i < 6; i++) begin
      a_data = 8'h11 + 8'(i);
      #1;
      checks += 3;
      if (a_ready !== 1'b1) begin errors++; $display("FAIL stream_a_ready[%0d] got=%0h exp=1", i, a_ready); end
      if (b_ready !== 1'b0) begin errors++; $display("FAIL stream_b_ready[%0d] got=%0h exp=0", i, b_ready); end
      if (sel !== 1'b0) begin errors++; $display("FAIL stream_sel[%0d] got=%0h exp=0", i, sel); end
      tick();
      checks += 2;
      if (y_valid !== 1'b1) begin errors++; $display("FAIL stream_y_valid[%0d] got=%0h exp=1", i, y_valid); end
      if (y_data !== 8'h11 + 8'(i)) begin errors++; $display("FAIL stream_y_data[%0d] got=%0h exp=%0h", i, y_data, 8'h11 + 8'(i)); end
    end
    a_valid = 0;
    tick();
    tick();
  endtask

  task automatic test_burst;
    int ia, ib;
    bit exp_b;
    do_reset();
    ia = 0; ib = 0;
    a_valid = 1; b_valid = 1; y_ready = 1;
    a_data = 8'hA0; b_data = 8'hB0;
    tick();
    for (int k = 0; k < 12; k++) begin
      exp_b = (k >= BL) && (k < 2 * BL);
      a_data = 8'hA0 + 8'(ia);
      b_data = 8'hB0 + 8'(ib);
      #1;
      checks += 2;
      if (a_ready !== !exp_b) begin errors++; $display("FAIL burst_a_ready[%0d] got=%0h exp=%0h", k, a_ready, !exp_b); end
      if (b_ready !== exp_b) begin errors++; $display("FAIL burst_b_ready[%0d] got=%0h exp=%0h", k, b_ready, exp_b); end
      tick();
      checks++;
      if (exp_b) begin
        if (y_data !== 8'hB0 + 8'(ib)) begin errors++; $display("FAIL burst_y_data[%0d] got=%0h exp=%0h", k, y_data, 8'hB0 + 8'(ib)); end
        ib++;
      end else begin
        if (y_data !== 8'hA0 + 8'(ia)) begin errors++; $display("FAIL burst_y_data[%0d] got=%0h exp=%0h", k, y_data, 8'hA0 + 8'(ia)); end
        ia++;
      end
    end
    a_valid = 0; b_valid = 0;
    tick();
    tick();
  endtask

  task automatic test_backpressure;
    do_reset();
    a_valid = 1; a_data = 8'h5A; y_ready = 1;
    tick();
    tick();
    y_ready = 0; a_data = 8'h77;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks += 4;
      if (a_ready !== 1'b0) begin errors++; $display("FAIL bp_a_ready[%0d] got=%0h exp=0", i, a_ready); end
      if (b_ready !== 1'b0) begin errors++; $display("FAIL bp_b_ready[%0d] got=%0h exp=0", i, b_ready); end
      if (y_valid !== 1'b1) begin errors++; $display("FAIL bp_y_valid[%0d] got=%0h exp=1", i, y_valid); end
      if (y_data !== 8'h5A) begin errors++; $display("FAIL bp_y_data[%0d] got=%0h exp=5a", i, y_data); end
      tick();
    end
    y_ready = 1;
    #1;
    checks++;
    if (a_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%0h exp=1", a_ready); end
    tick();
    checks += 2;
    if (y_data !== 8'h77) begin errors++; $display("FAIL bp_release_data got=%0h exp=77", y_data); end
    if (y_valid !== 1'b1) begin errors++; $display("FAIL bp_release_valid got=%0h exp=1", y_valid); end
    a_valid = 0;
    tick();
    tick();
  endtask

  task automatic test_saturate;
    do_reset();
    a_valid = 1; y_ready = 1; a_data = 8'h01;
    tick();
    for (int i = 0; i < BL + 2; i++) begin
      a_data = 8'h20 + 8'(i);
      tick();
    end
    checks++;
    if (y_data !== 8'h20 + 8'(BL + 1)) begin errors++; $display("FAIL sat_stream_data got=%0h exp=%0h", y_data, 8'h20 + 8'(BL + 1)); end
    b_valid = 1; b_data = 8'h3C;
    #1;
    checks += 3;
    if (a_ready !== 1'b0) begin errors++; $display("FAIL sat_a_drop got=%0h exp=0", a_ready); end
    if (b_ready !== 1'b0) begin errors++; $display("FAIL sat_b_early got=%0h exp=0", b_ready); end
    if (sel !== 1'b0) begin errors++; $display("FAIL sat_sel_pre got=%0h exp=0", sel); end
    tick();
    checks += 2;
    if (sel !== 1'b1) begin errors++; $display("FAIL sat_sel_post got=%0h exp=1", sel); end
    if (b_ready !== 1'b1) begin errors++; $display("FAIL sat_b_ready got=%0h exp=1", b_ready); end
    tick();
    checks++;
    if (y_data !== 8'h3C) begin errors++; $display("FAIL sat_b_data got=%0h exp=3c", y_data); end
    a_valid = 0; b_valid = 0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid;
    do_reset();
    a_valid = 1; b_valid = 1; y_ready = 1;
    a_data = 8'hC1; b_data = 8'hD1;
    tick();
    tick();
    tick();
    checks++;
    if (y_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got=%0h exp=1", y_valid); end
    reset = 1;
    tick();
    reset = 0;
    #1;
    checks += 5;
    if (y_valid !== 1'b0) begin errors++; $display("FAIL mid_y_valid got=%0h exp=0", y_valid); end
    if (y_data !== 8'h00) begin errors++; $display("FAIL mid_y_data got=%0h exp=0", y_data); end
    if (sel !== 1'b0) begin errors++; $display("FAIL mid_sel got=%0h exp=0", sel); end
    if (a_ready !== 1'b0) begin errors++; $display("FAIL mid_a_ready got=%0h exp=0", a_ready); end
    if (b_ready !== 1'b0) begin errors++; $display("FAIL mid_b_ready got=%0h exp=0", b_ready); end
    tick();
    checks += 2;
    if (sel !== 1'b0) begin errors++; $display("FAIL mid_tie_sel got=%0h exp=0", sel); end
    if (a_ready !== 1'b1) begin errors++; $display("FAIL mid_tie_a_ready got=%0h exp=1", a_ready); end
    a_valid = 0; b_valid = 0;
    tick();
    tick();
  endtask

  task automatic test_random;
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      reset   = ($urandom_range(0, 79) == 0);
      a_valid = ($urandom_range(0, 3) != 0);
      b_valid = ($urandom_range(0, 2) != 0);
      y_ready = ($urandom_range(0, 9) < 7);
      a_data  = 8'($urandom);
      b_data  = 8'($urandom);
      #1;
      model_comb();
      checks += 5;
      if (a_ready !== m_ar) begin errors++; $display("FAIL rnd_a_ready[%0d] got=%0h exp=%0h", c, a_ready, m_ar); end
      if (b_ready !== m_br) begin errors++; $display("FAIL rnd_b_ready[%0d] got=%0h exp=%0h", c, b_ready, m_br); end
      if (sel !== (m_own == 2)) begin errors++; $display("FAIL rnd_sel[%0d] got=%0h exp=%0h", c, sel, m_own == 2); end
      if (y_valid !== m_yv) begin errors++; $display("FAIL rnd_y_valid[%0d] got=%0h exp=%0h", c, y_valid, m_yv); end
      if (y_data !== m_yd) begin errors++; $display("FAIL rnd_y_data[%0d] got=%0h exp=%0h", c, y_data, m_yd); end
      tick();
      model_tick();
    end
    reset = 0;
  endtask

  initial begin
    reset = 1;
    a_valid = 0; b_valid = 0; y_ready = 0;
    a_data = 0; b_data = 0;
    test_reset();
    test_a_stream();
    test_burst();
    test_backpressure();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares one 2:1 data mux between two valid/ready requesters (A and B) and presents the winner on a single registered valid/ready output. It owns the mux select: it decides which requester drives the output, holds the grant for bounded bursts, and rotates fairly. It sits directly in front of any downstream consumer that previously took a raw 2:1 mux output.

## Interface
- DATA_W, 8, width of each data path
- BURST_LEN, 4, maximum consecutive transfers accepted from one requester while the other is waiting; legal range 1..15
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- a_valid_i  input  1  requester A has data
- a_data_i  input  DATA_W  requester A data
- a_ready_o  output  1  A transfer accepted this cycle when high with a_valid_i
- b_valid_i  input  1  requester B has data
- b_data_i  input  DATA_W  requester B data
- b_ready_o  output  1  B transfer accepted this cycle when high with b_valid_i
- y_valid_o  output  1  output register holds valid data
- y_data_o  output  DATA_W  output data
- y_ready_i  input  1  downstream accepts y_data_o this cycle
- sel_o  output  1  current mux select: 0 = A, 1 = B (registered)

## Operation
- States: IDLE, GRANT_A, GRANT_B. Registers: state, cnt (4 bits), last (last requester served), output register.
- slot_free = !y_valid_o || y_ready_i.
- a_ready_o = (state==GRANT_A) && slot_free && !(cnt==BURST_LEN && b_valid_i); b_ready_o symmetric. Both 0 in IDLE.
- Transfer X fires when x_valid_i && x_ready_o; cnt_next = cnt + fire (saturates at BURST_LEN).
- IDLE: both valid -> grant to requester != last; only one valid -> grant it; none -> stay. cnt cleared on every grant entry.
- GRANT_X: next = GRANT_other if other_valid && (cnt_next==BURST_LEN || !x_valid_i); next = IDLE if !x_valid_i && !other_valid; else stay. last <= X on exit from GRANT_X.
- A switch between grants never inserts a bubble on the input side beyond the edge itself; entry from IDLE costs one cycle.
- Output register: on fire load y_data_o with the selected data and set y_valid_o; else if y_ready_i clear y_valid_o; else hold data and valid (stable under backpressure).
- sel_o = 1 iff state==GRANT_B; 0 in IDLE.
- Requester dropping valid without a transfer is legal; no data is lost since nothing was accepted.

## Timing
- Reset values: state IDLE, cnt 0, last = B (so A wins first tie), y_valid_o 0, y_data_o 0, sel_o 0, a_ready_o 0, b_ready_o 0.
- Reset mid-burst: all state returns to reset values on the next edge; output register content is discarded.
- Latency: transfer accepted at edge N -> y_valid_o/y_data_o visible after edge N (one cycle).
- Throughput: one transfer per cycle while y_ready_i stays high and grant unchanged.
- Backpressure: y_valid_o && !y_ready_i -> both readys 0, cnt and state hold unless the granted requester drops valid.
- Simultaneous y_ready_i drain and new fire: output register loads new data, y_valid_o stays 1.
- BURST_LEN boundary: cnt reaching BURST_LEN with other idle -> current requester keeps streaming (cnt saturated); other asserting valid then forces ready low for current and switch on the next edge.

## Structure
- Package mux_arb_pkg: state enum typedef (IDLE, GRANT_A, GRANT_B), DATA_W default, BURST_LEN default, cnt width constant.
- One sub-module is natural: mux_out_reg, the valid/data output register with load/drain/hold logic and slot_free output.
- Arbiter FSM, counter and ready logic stay in mux_rr_arbiter.

## Test plan
- Reset then idle: all outputs 0, sel_o 0 after reset release with no valids.
- A only, a_data_i = 8'h11..8'h16 streamed, y_ready_i = 1 -> six y_data_o values in order, one cycle after each accept, sel_o = 0 throughout, b_ready_o = 0.
- Both valid from IDLE, BURST_LEN = 4 -> A accepted 4 times (8'hA0..8'hA3), then B 4 times (8'hB0..8'hB3), then A; no input bubble at switches.
- Backpressure: y_data_o = 8'h5A with y_ready_i low 3 cycles -> y_data_o holds 8'h5A, readys 0, cnt unchanged; release -> next data accepted same cycle.
- A holds grant with cnt saturated, B asserts valid with 8'h3C -> a_ready_o drops that cycle, grant switches next edge, 8'h3C out one cycle after accept.
- Reset asserted mid-burst with y_valid_o = 1 -> next edge all outputs at reset values, first post-reset tie grants A.
